// File: rtl/pool_scheduler.sv
// pool_scheduler: walks every channel of a layer through the 2x2 max-pool unit.
// Optional drain watchdog / overflow error flag: `define POOL_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module pool_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CHANNELS   = 6,
  parameter int NUM_ROWS       = 28,
  parameter int NUM_COLUMNS    = 28,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int OUT_PER_CH    = (NUM_ROWS / 2) * (NUM_COLUMNS / 2),
  localparam int IN_AW         = $clog2(NUM_CHANNELS * NUM_ROWS * NUM_COLUMNS),
  localparam int OUT_AW        = $clog2(NUM_CHANNELS * OUT_PER_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_go,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [IN_AW-1:0]      o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_pool_start,
  output logic                  o_pool_clr,
  output logic [DATA_WIDTH-1:0] o_pool_data,
  input  logic                  i_pool_nd,
  input  logic [DATA_WIDTH-1:0] i_pool_data,
  output logic                  o_wr_en,
  output logic [OUT_AW-1:0]     o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_err
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int OC_W  = $clog2(OUT_PER_CH + 1);

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, NEXT, DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [OC_W-1:0]   out_cnt;
  logic [OUT_AW-1:0] wr_ptr;
  logic              cnt_full;

  // wr_ptr tracks ch*OUT_PER_CH + out_cnt incrementally instead of multiplying.
  assign cnt_full = (out_cnt == OC_W'(OUT_PER_CH));

`ifdef POOL_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      ch           <= '0;
      row          <= '0;
      col          <= '0;
      out_cnt      <= '0;
      wr_ptr       <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_pool_start <= 1'b0;
      o_pool_clr   <= 1'b0;
      o_pool_data  <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
`ifdef POOL_SCHED_TIMEOUT_EN
      wd           <= '0;
      o_err        <= 1'b0;
`endif
    end else begin
      o_pool_data  <= i_rd_data;
      o_pool_start <= 1'b0;
      o_pool_clr   <= 1'b0;
      o_done       <= 1'b0;
      o_wr_en      <= 1'b0;

      // Pool results are accepted in any active state; extras past a full channel are dropped.
      if (state != IDLE && i_pool_nd) begin
        if (!cnt_full) begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= wr_ptr;
          o_wr_data <= i_pool_data;
          wr_ptr    <= wr_ptr + 1'b1;
          out_cnt   <= out_cnt + 1'b1;
        end
`ifdef POOL_SCHED_TIMEOUT_EN
        else begin
          o_err <= 1'b1;
        end
`endif
      end

      case (state)
        IDLE: begin
          if (i_go) begin
            state        <= START;
            o_busy       <= 1'b1;
            o_pool_start <= 1'b1;
          end
        end
        START: begin
          state   <= STREAM;
          o_rd_en <= 1'b1;
`ifdef POOL_SCHED_TIMEOUT_EN
          wd      <= '0;
`endif
        end
        STREAM: begin
          // Reads are contiguous across channels, so the address just increments.
          o_rd_addr <= o_rd_addr + 1'b1;
          if (col == COL_W'(NUM_COLUMNS - 1)) begin
            col <= '0;
            if (row == ROW_W'(NUM_ROWS - 1)) begin
              row     <= '0;
              o_rd_en <= 1'b0;
              state   <= DRAIN;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_full) begin
            state      <= NEXT;
            o_pool_clr <= 1'b1;
          end
`ifdef POOL_SCHED_TIMEOUT_EN
          else if (i_pool_nd) begin
            wd <= '0;
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            o_err      <= 1'b1;
            o_pool_clr <= 1'b1;
            o_done     <= 1'b1;
            state      <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        NEXT: begin
          out_cnt <= '0;
          if (ch == CH_W'(NUM_CHANNELS - 1)) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            ch           <= ch + 1'b1;
            state        <= START;
            o_pool_start <= 1'b1;
          end
        end
        DONE: begin
          ch        <= '0;
          out_cnt   <= '0;
          wr_ptr    <= '0;
          o_rd_addr <= '0;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
